// File: rtl/otter_pkg.sv
// otter_pkg: shared OTTER types and constants for the fetch stage.
package otter_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL} pc_src_t;
    typedef enum logic [1:0] {IDLE, REQ, DROP, FULL} fetch_state_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
    } if_de_t;
    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction
    function automatic logic [31:0] sat_inc(input logic [31:0] a);
        return &a ? a : a + 32'd1;
    endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {pc, ir} holding register that catches a response arriving during a stall.
module fetch_skid (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_ir,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] ir
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            pc    <= '0;
            ir    <= '0;
        end else begin
            valid <= clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid;
            if (load && !clear) begin
                pc <= load_pc;
                ir <= load_ir;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: OTTER IF stage -- owns the PC, fetches over imem req/ack, loads IF/DE with a one-entry skid.
// Define FETCH_PERF_EN to add saturating stall/flush/drop counters as extra outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = otter_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load_use_haz,
    input  logic        flush,
    input  logic [1:0]  pc_source,
    input  logic [31:0] jalr_addr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jal_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_de_valid,
    output logic [31:0] if_de_pc,
    output logic [31:0] if_de_ir
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_drop_count
`endif
);
    import otter_pkg::*;

    fetch_state_t state, state_n;
    pc_src_t      src;
    if_de_t       if_de, if_de_n, bubble;
    logic [31:0]  pc, pc_n, req_addr, req_addr_n, target, skid_pc, skid_ir;
    logic         ack, outstanding, issue, skid_valid, skid_load, skid_drain, skid_clear;

    assign src         = pc_src_t'(pc_source);
    assign outstanding = state == REQ || state == DROP;
    assign ack         = outstanding && imem_ack;
    assign target      = src == PC_JALR   ? align(jalr_addr)   :
                         src == PC_BRANCH ? align(branch_addr) :
                         src == PC_JAL    ? align(jal_addr)    : pc;
    assign bubble      = {1'b0, if_de.pc, NOP_INSTR};
    assign imem_req    = outstanding;
    assign imem_addr   = req_addr;
    assign if_de_valid = if_de.valid;
    assign if_de_pc    = if_de.pc;
    assign if_de_ir    = if_de.ir;

    fetch_skid skid (
        .CLK(CLK), .RST(RST), .load(skid_load), .drain(skid_drain), .clear(skid_clear),
        .load_pc(req_addr), .load_ir(imem_rdata), .valid(skid_valid), .pc(skid_pc), .ir(skid_ir)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            if_de    <= {1'b0, 32'h0, NOP_INSTR};
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            if_de    <= if_de_n;
        end
    end

    // An unstalled cycle with nothing new to deliver inserts a bubble so decode never sees a duplicate.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        if_de_n    = load_use_haz ? if_de : bubble;
        issue      = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            pc_n       = target;
            if_de_n    = bubble;
            skid_clear = 1'b1;
            state_n    = outstanding && !ack ? DROP : IDLE;
        end else begin
            case (state)
                IDLE: issue = 1'b1;
                REQ: if (ack) begin
                    if (load_use_haz || skid_valid) begin
                        skid_load = 1'b1;
                        state_n   = FULL;
                        if (!load_use_haz) if_de_n = {1'b1, skid_pc, skid_ir};
                    end else begin
                        if_de_n = {1'b1, req_addr, imem_rdata};
                        issue   = 1'b1;
                    end
                end
                DROP: if (ack) state_n = IDLE;
                FULL: if (!load_use_haz) begin
                    if_de_n    = {1'b1, skid_pc, skid_ir};
                    skid_drain = 1'b1;
                    issue      = 1'b1;
                end
                default: ;
            endcase
        end
        if (issue) begin
            req_addr_n = pc;
            pc_n       = pc + 32'd4;
            state_n    = REQ;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
            perf_drop_count   <= '0;
        end else begin
            if (load_use_haz) perf_stall_cycles <= sat_inc(perf_stall_cycles);
            if (flush) perf_flush_count <= sat_inc(perf_flush_count);
            if (ack && (state == DROP || flush)) perf_drop_count <= sat_inc(perf_drop_count);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with a delivery scoreboard; memory returns rdata = addr.
module tb_fetch_unit;
    logic        CLK = 0, RST = 0, load_use_haz = 0, flush = 0;
    logic        imem_req, imem_ack, if_de_valid;
    logic        force_ack = 0, mem_en = 1, haz_edge = 0;
    logic [1:0]  pc_source = 2'b00;
    logic [31:0] jalr_addr = 0, branch_addr = 0, jal_addr = 0;
    logic [31:0] imem_addr, imem_rdata, if_de_pc, if_de_ir;
    int          lat = 0, cnt = 0, tests = 0, fails = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK(CLK), .RST(RST), .load_use_haz(load_use_haz), .flush(flush), .pc_source(pc_source),
        .jalr_addr(jalr_addr), .branch_addr(branch_addr), .jal_addr(jal_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_de_valid(if_de_valid), .if_de_pc(if_de_pc), .if_de_ir(if_de_ir)
    );

    // lat = number of waiting cycles before ack; 0 acks in the cycle the request is seen
    assign imem_ack   = force_ack | (mem_en & imem_req & (cnt >= lat));
    assign imem_rdata = imem_addr;
    always @(posedge CLK) cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A valid IF/DE slot after an unstalled edge is a fresh delivery and must match the queue head.
    task automatic mon();
        logic [31:0] e;
        if (if_de_valid && !haz_edge) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL deliver_extra: got pc %h expected no delivery", if_de_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("deliver_pc", if_de_pc, e);
                chk("deliver_ir", if_de_ir, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        mon();
        haz_edge = load_use_haz;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_valid"}, if_de_valid, 0);
        chk({tag, "_pc"}, if_de_pc, 0);
        chk({tag, "_ir"}, if_de_ir, 32'h13);
    endtask

    initial begin
        RST = 1;
        tick();
        tick();
        chk_reset("rst");
        RST = 0;
        exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12);
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        tick();
        chk("addr_4", imem_addr, 4);
        tick();
        chk("addr_8", imem_addr, 8);
        tick();
        load_use_haz = 1;
        tick();
        chk("stall_noreq", imem_req, 0);
        chk("stall_hold_pc", if_de_pc, 8);
        chk("stall_hold_valid", if_de_valid, 1);
        tick();
        load_use_haz = 0;
        chk("full_noreq", imem_req, 0);
        chk("full_hold_pc", if_de_pc, 8);
        tick();
        chk("drain_pc", if_de_pc, 12);
        chk("drain_next_addr", imem_addr, 16);
        mem_en = 0;
        lat = 2;
        tick();
        mem_en = 1;
        flush = 1;
        pc_source = 2'b10;
        branch_addr = 32'h100;
        exp_q.push_back(32'h100);
        tick();
        flush = 0;
        chk("drop_req", imem_req, 1);
        chk("drop_addr", imem_addr, 16);
        chk("flush_valid", if_de_valid, 0);
        tick();
        tick();
        chk("branch_req", imem_req, 1);
        chk("branch_addr", imem_addr, 32'h100);
        tick();
        tick();
        chk("wait_valid", if_de_valid, 0);
        tick();
        tick();
        tick();
        load_use_haz = 1;
        tick();
        flush = 1;
        pc_source = 2'b11;
        jal_addr = 32'h300;
        exp_q.push_back(32'h300);
        tick();
        flush = 0;
        load_use_haz = 0;
        lat = 0;
        chk("flush_stall_valid", if_de_valid, 0);
        chk("flush_stall_req", imem_req, 0);
        tick();
        chk("jal_addr", imem_addr, 32'h300);
        tick();
        flush = 1;
        pc_source = 2'b01;
        jalr_addr = 32'h203;
        exp_q.push_back(32'h200);
        tick();
        flush = 0;
        chk("jalr_flush_valid", if_de_valid, 0);
        tick();
        chk("jalr_aligned", imem_addr, 32'h200);
        tick();
        flush = 1;
        pc_source = 2'b11;
        jal_addr = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        flush = 0;
        tick();
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        mem_en = 0;
        chk("wrap_addr", imem_addr, 0);
        tick();
        flush = 1;
        pc_source = 2'b00;
        tick();
        flush = 0;
        chk("drop2_req", imem_req, 1);
        RST = 1;
        #1;
        chk_reset("midrst");
        tick();
        RST = 0;
        force_ack = 1;
        exp_q.push_back(0);
        tick();
        force_ack = 0;
        mem_en = 1;
        chk("stray_ack_valid", if_de_valid, 0);
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 0);
        tick();
        mem_en = 0;
        tick();
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined OTTER core. It sits directly upstream of the hazard unit and decode. It owns the PC, issues requests to instruction memory over a req/ack handshake, and loads the IF/DE pipeline register. It consumes the hazard unit's `load_use_haz` (stall) and `flush`/`pc_source` (redirect) outputs, and includes a one-entry skid buffer so that no fetch is lost during a stall.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `if_de_ir` when the slot is invalid.

Ports:
- `CLK` in 1: single clock. All state updates on the rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `load_use_haz` in 1: stall. Hold IF/DE and do not advance the PC.
- `flush` in 1: redirect/flush from the hazard unit.
- `pc_source` in 2: next-PC select. 00 = pc+4, 01 = jalr, 10 = branch, 11 = jal.
- `jalr_addr`, `branch_addr`, `jal_addr` in 32 each: redirect targets from EX.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched instruction.
- `if_de_valid` out 1: IF/DE slot holds a real instruction.
- `if_de_pc` out 32: PC of the IF/DE instruction.
- `if_de_ir` out 32: IF/DE instruction.

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, its response will be kept.
  - DROP: request outstanding, its response will be discarded.
  - FULL: the skid buffer is occupied and no request is outstanding.
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: the address of the outstanding request. `imem_addr` = `req_addr` while `imem_req` is high.
  - `skid_valid`, `skid_pc`, `skid_ir`: the skid buffer.
- Handshake: `imem_req` stays high and `req_addr` stays stable until an `imem_ack` is sampled. `imem_ack` may arrive in the same cycle the request is raised. `imem_ack` while `imem_req` is low is ignored.
- Issue: in IDLE, or in REQ on the ack cycle, a new request to `pc` is issued in that cycle and `pc` <= `pc`+4. No issue happens when the skid buffer is full or `load_use_haz`=1 with the skid occupied.
- Response handling (REQ, on ack):
  - If `load_use_haz`=0 and the skid buffer is empty: IF/DE <= {1, `req_addr`, `imem_rdata`}.
  - If `load_use_haz`=0 and the skid buffer holds data: the skid contents go to IF/DE and the new response goes to the skid.
  - If `load_use_haz`=1: IF/DE holds; the response goes to the skid. Go to FULL (no new issue).
- FULL: when `load_use_haz`=0, the skid moves to IF/DE, the skid is cleared, a request to `pc` is issued, and the state goes to REQ.
- Stall, no ack: IF/DE holds and the outstanding request is maintained.
- Flush (priority over stall and over any ack in the same cycle):
  - `pc` <= target selected by `pc_source` (00 keeps `pc`).
  - `if_de_valid` <= 0 and `if_de_ir` <= `NOP_INSTR`.
  - The skid buffer is cleared.
  - If a request is outstanding and not acked this cycle, the state goes to DROP. Otherwise it goes to IDLE.
- DROP: keep `imem_req`/`req_addr` until ack, discard `imem_rdata`, then go to IDLE. A further flush in DROP only updates `pc`.
- Alignment: targets have bits [1:0] forced to 00. PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_de_valid`=0, `if_de_pc`=0, `if_de_ir`=`NOP_INSTR`.
  - `pc`=`RESET_PC`, state IDLE, skid empty.
- First request is issued in the first cycle after `RST` deasserts.
- Latency: ack in cycle N means the instruction is visible on IF/DE in cycle N+1.
- Throughput: with a same-cycle-ack memory, `imem_req` stays high and one instruction is delivered per cycle.
- Flush in cycle N:
  - IF/DE is invalid in N+1.
  - The first request to the target is issued in N+1 if nothing was outstanding, else in the cycle after the dropped ack.
- `RST` mid-transaction: immediate return to reset values. A late `imem_ack` after reset is ignored because the state is IDLE.

## Configuration
- `FETCH_PERF_EN`:
  - Defined: adds 32-bit saturating counters `perf_stall_cycles`, `perf_flush_count`, `perf_drop_count` as extra outputs. They are cleared by `RST`.
  - Undefined: the ports and logic are absent and behaviour is otherwise identical.

## Structure
- Shared package `otter_pkg`:
  - `pc_src_t` enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL).
  - `fetch_state_t` enum.
  - `if_de_t` struct {valid, pc, ir}.
  - constant `NOP_INSTR`.
- One natural sub-module: `fetch_skid`, the one-entry skid register with load/drain/clear.

## Test plan
- Reset release with an always-ack memory (rdata = addr): `imem_addr` sequence 0, 4, 8; IF/DE shows pc 0/ir 0 one cycle after the first ack, then one instruction per cycle.
- `load_use_haz` high for 2 cycles while an ack arrives: IF/DE holds the old instruction, the skid captures the acked one, and no new request is issued. After release the order is preserved with no duplicate or lost PC.
- Flush with `pc_source`=10 and `branch_addr`=32'h100 on a 3-cycle-latency memory mid-request: the old response is dropped, the next `imem_addr`=32'h100, and `if_de_valid`=0 until it returns.
- Flush and `load_use_haz` in the same cycle: the flush wins, IF/DE is invalid next cycle, and the skid is cleared.
- `jalr_addr`=32'h203 redirect: fetch goes to 32'h200. `pc` at 32'hFFFF_FFFC advances to 0.
- Assert `RST` while in DROP, then ack next cycle: outputs return to reset values and the stray ack is ignored.
